// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter: two-master (m0 = sampler, m1 = computer) to one-slave APB
// arbiter in front of the shared RAM. Round-robin grant; each granted transfer
// is replayed to the slave as a clean SETUP/ACCESS pair while the other master
// stalls with pready low.
// Optional build macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase watchdog
// (TIMEOUT cycles) that completes the transfer with pslverr and exposes the
// m0_pslverr / m1_pslverr ports.
module apb_ram_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  // master 0 (sampler)
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic              m0_pready,
  output logic [DATA_W-1:0] m0_prdata,
  // master 1 (computer)
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic              m1_pready,
  output logic [DATA_W-1:0] m1_prdata,
  // slave (shared RAM)
  output logic              s_psel,
  output logic              s_penable,
  output logic              s_pwrite,
  output logic [ADDR_W-1:0] s_paddr,
  output logic [DATA_W-1:0] s_pwdata,
  input  logic              s_pready,
  input  logic [DATA_W-1:0] s_prdata,
`ifdef APB_ARB_TIMEOUT_EN
  output logic              m0_pslverr,
  output logic              m1_pslverr,
`endif
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  // index of the master served most recently; 1 after reset so m0 wins the first tie
  logic       last_q, last_d;

  logic       tout;       // watchdog expiry in the current ACCESS cycle
  logic       done;       // current ACCESS cycle completes the transfer
  logic       ok_beat;    // completion with real slave data

  // penable is not part of the request; arbitration uses psel only
  logic       unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  // TIMEOUT of zero leaves no ACCESS cycle in which the watchdog could fire
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("apb_ram_arbiter: TIMEOUT must be at least 1");
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // watchdog counter: cleared on entry to SETUP, counts stalled ACCESS cycles
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && state_d == ST_SETUP) begin
      cnt_d = '0;
    end else if (state_q == ST_ACCESS && !s_pready && !tout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // watchdog register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tout = (state_q == ST_ACCESS) && !s_pready &&
                (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign tout = 1'b0;
`endif

  assign ok_beat = (state_q == ST_ACCESS) && s_pready;
  assign done    = ok_beat || tout;

  // arbiter state, grant and round-robin pointer registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // next-state, grant selection and round-robin update
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (m0_psel && m1_psel) begin
          gnt_d = last_q ? 2'b01 : 2'b10;
        end else if (m0_psel) begin
          gnt_d = 2'b01;
        end else if (m1_psel) begin
          gnt_d = 2'b10;
        end
        if (m0_psel || m1_psel) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // a master dropping psel here does not cancel the slave transfer
        if (done) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          last_d  = gnt_q[1];
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // slave-side control and granted-master address/data/direction mux
  always_comb begin
    s_psel    = (state_q != ST_IDLE);
    s_penable = (state_q == ST_ACCESS);
    s_pwrite  = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    if (state_q != ST_IDLE) begin
      if (gnt_q[1]) begin
        s_pwrite = m1_pwrite;
        s_paddr  = m1_paddr;
        s_pwdata = m1_pwdata;
      end else if (gnt_q[0]) begin
        s_pwrite = m0_pwrite;
        s_paddr  = m0_paddr;
        s_pwdata = m0_pwdata;
      end
    end
  end

  // master-side completion: only the granted master ever sees pready/prdata,
  // and read data is forwarded solely in the completing cycle (never latched)
  always_comb begin
    m0_pready = done && gnt_q[0];
    m1_pready = done && gnt_q[1];
    m0_prdata = '0;
    m1_prdata = '0;
    if (ok_beat && gnt_q[0]) begin
      m0_prdata = s_prdata;
    end
    if (ok_beat && gnt_q[1]) begin
      m1_prdata = s_prdata;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  assign m0_pslverr = tout && gnt_q[0];
  assign m1_pslverr = tout && gnt_q[1];
`endif

  assign gnt = gnt_q;

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Self-checking bench for apb_ram_arbiter: behavioural RAM slave with
// programmable wait states, per-master expected-completion queues and an
// expected grant-order queue checked whenever a master sees pready.
// Define APB_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_apb_ram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          m0_psel, m0_penable, m0_pwrite;
  logic [AW-1:0] m0_paddr;
  logic [DW-1:0] m0_pwdata, m0_prdata;
  logic          m0_pready;
  logic          m1_psel, m1_penable, m1_pwrite;
  logic [AW-1:0] m1_paddr;
  logic [DW-1:0] m1_pwdata, m1_prdata;
  logic          m1_pready;
  logic          s_psel, s_penable, s_pwrite, s_pready;
  logic [AW-1:0] s_paddr;
  logic [DW-1:0] s_pwdata, s_prdata;
  logic [1:0]    gnt;
`ifdef APB_ARB_TIMEOUT_EN
  logic          m0_pslverr, m1_pslverr;
`endif

  always #5 pclk = ~pclk;

  apb_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pready(m0_pready), .m0_prdata(m0_prdata),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pready(m1_pready), .m1_prdata(m1_prdata),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pready(s_pready), .s_prdata(s_prdata),
`ifdef APB_ARB_TIMEOUT_EN
    .m0_pslverr(m0_pslverr), .m1_pslverr(m1_pslverr),
`endif
    .gnt(gnt)
  );

  // ---------------- behavioural RAM slave ----------------
  logic [DW-1:0] mem [0:255];
  int            slv_waits = 0;
  logic          slv_hang  = 1'b0;
  int            wcnt      = 0;

  assign s_pready = s_psel && s_penable && !slv_hang && (wcnt == slv_waits);
  assign s_prdata = s_pready ? mem[s_paddr] : 32'hBAD0_BAD0;

  always @(posedge pclk) begin
    if (s_psel && s_penable && !s_pready) wcnt <= wcnt + 1;
    else                                  wcnt <= 0;
    if (s_pready && s_pwrite) mem[s_paddr] <= s_pwdata;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          err;
  } xfer_t;

  xfer_t      q0[$];
  xfer_t      q1[$];
  logic [1:0] gq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_done(input int m);
    xfer_t       e;
    logic [DW-1:0] rd;
    logic        err;
    rd = (m == 0) ? m0_prdata : m1_prdata;
`ifdef APB_ARB_TIMEOUT_EN
    err = (m == 0) ? m0_pslverr : m1_pslverr;
`else
    err = 1'b0;
`endif
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      chk("unexpected_pready", 32'(m), 32'hFFFF_FFFF);
      return;
    end
    e = (m == 0) ? q0.pop_front() : q1.pop_front();
    chk("done_addr", 32'(s_paddr), 32'(e.a));
    chk("done_dir", 32'(s_pwrite), 32'(e.wr));
    chk("done_pslverr", 32'(err), 32'(e.err));
    if (e.err)      chk("err_rdata", rd, 0);
    else if (e.wr)  chk("wdata", s_pwdata, e.d);
    else            chk("rdata", rd, e.d);
    if (gq.size() > 0) chk("gnt_order", 32'(gnt), 32'(gq.pop_front()));
  endtask

  // per-cycle monitor, sampled mid-cycle
  always @(negedge pclk) begin
    if (presetn) begin
      chk("m0_rdata_quiet", m0_pready ? 32'h0 : m0_prdata, 0);
      chk("m1_rdata_quiet", m1_pready ? 32'h0 : m1_prdata, 0);
      if (m0_pready) begin
        chk("m0_gnt", 32'(gnt), 32'h1);
        chk("m1_rdy_excl", 32'(m1_pready), 0);
        check_done(0);
      end
      if (m1_pready) begin
        chk("m1_gnt", 32'(gnt), 32'h2);
        check_done(1);
      end
    end
  end

  // ---------------- master driver ----------------
  // called #1 after a rising edge; returns #1 after the completing edge
  task automatic mx(input int m, input logic wr, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic keep);
    xfer_t e;
    logic  got;
    e.wr = wr; e.a = a; e.d = d; e.err = 1'b0;
    if (m == 0) begin
      q0.push_back(e);
      m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d;
    end else begin
      q1.push_back(e);
      m1_psel = 1'b1; m1_penable = 1'b0; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d;
    end
    @(posedge pclk); #1;
    if (m == 0) m0_penable = 1'b1; else m1_penable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pclk);
      if ((m == 0) ? m0_pready : m1_pready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("pready_wait", 0, 1);
    @(posedge pclk); #1;
    if (m == 0) begin
      m0_penable = 1'b0;
      if (!keep) m0_psel = 1'b0;
    end else begin
      m1_penable = 1'b0;
      if (!keep) m1_psel = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int acc;
    xfer_t e;
    presetn = 1'b0;
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
    m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_s_psel", 32'(s_psel), 0);
    chk("rst_s_penable", 32'(s_penable), 0);
    chk("rst_s_paddr", 32'(s_paddr), 0);
    chk("rst_m0_pready", 32'(m0_pready), 0);
    chk("rst_m1_pready", 32'(m1_pready), 0);
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;

    // single write with exact latency checks
    @(posedge pclk); #1;
    e.wr = 1; e.a = 8'h10; e.d = 32'hA5A5_0001; e.err = 0;
    q0.push_back(e);
    m0_psel = 1; m0_pwrite = 1; m0_paddr = 8'h10; m0_pwdata = 32'hA5A5_0001;
    @(negedge pclk);
    chk("sw_idle_psel", 32'(s_psel), 0);
    @(negedge pclk);
    chk("sw_setup_psel", 32'(s_psel), 1);
    chk("sw_setup_penable", 32'(s_penable), 0);
    chk("sw_setup_gnt", 32'(gnt), 1);
    chk("sw_setup_paddr", 32'(s_paddr), 32'h10);
    chk("sw_setup_pwrite", 32'(s_pwrite), 1);
    chk("sw_setup_m0_pready", 32'(m0_pready), 0);
    @(posedge pclk); #1 m0_penable = 1;
    @(negedge pclk);
    chk("sw_access_penable", 32'(s_penable), 1);
    chk("sw_access_m0_pready", 32'(m0_pready), 1);
    chk("sw_access_m1_pready", 32'(m1_pready), 0);
    @(posedge pclk); #1 m0_psel = 0; m0_penable = 0;
    @(negedge pclk);
    chk("sw_after_psel", 32'(s_psel), 0);
    chk("sw_after_gnt", 32'(gnt), 0);

    // read back through the other master
    @(posedge pclk); #1;
    mx(1, 0, 8'h10, 32'hA5A5_0001, 0);

    // simultaneous requests: m0 first, then m1
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      mx(0, 1, 8'h30, 32'h1111_1111, 0);
      mx(1, 1, 8'h31, 32'h2222_2222, 0);
    join
    mx(0, 0, 8'h31, 32'h2222_2222, 0);
    mx(1, 0, 8'h30, 32'h1111_1111, 0);

    // fairness: both hold psel for six transfers
    for (int i = 0; i < 3; i++) begin
      gq.push_back(2'b01); gq.push_back(2'b10);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) mx(0, 1, 8'(8'h40 + i), 32'h4000_0000 + i, (i < 2));
      end
      begin
        for (int i = 0; i < 3; i++) mx(1, 1, 8'(8'h50 + i), 32'h5000_0000 + i, (i < 2));
      end
    join
    mx(0, 0, 8'h42, 32'h4000_0002, 0);
    mx(1, 0, 8'h50, 32'h5000_0000, 0);

    // read with three wait states
    mx(0, 1, 8'h20, 32'hDEAD_BEEF, 0);
    slv_waits = 3;
    acc = 0;
    fork
      mx(1, 0, 8'h20, 32'hDEAD_BEEF, 0);
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge pclk);
          if (s_psel && s_penable) begin
            acc++;
            chk("rd_paddr_stable", 32'(s_paddr), 32'h20);
            if (!m1_pready) chk("rd_no_early_data", m1_prdata, 0);
          end
          if (m1_pready) break;
        end
      end
    join
    chk("rd_access_cycles", acc, 4);
    slv_waits = 0;

    // leave m0 as last served so a lost reset of the pointer would favour m1
    mx(0, 0, 8'h20, 32'hDEAD_BEEF, 0);

    // reset during ACCESS
    slv_waits = 5;
    m0_psel = 1; m0_pwrite = 1; m0_paddr = 8'h60; m0_pwdata = 32'h6666_6666;
    @(negedge pclk);
    @(negedge pclk);
    @(posedge pclk); #1 m0_penable = 1;
    @(negedge pclk);
    chk("rst_mid_in_access", 32'(s_penable), 1);
    #1 presetn = 0;
    #1;
    chk("rst_mid_s_psel", 32'(s_psel), 0);
    chk("rst_mid_s_penable", 32'(s_penable), 0);
    chk("rst_mid_gnt", 32'(gnt), 0);
    chk("rst_mid_m0_pready", 32'(m0_pready), 0);
    chk("rst_mid_s_paddr", 32'(s_paddr), 0);
    m0_psel = 0; m0_penable = 0;
    @(posedge pclk); #1;
    slv_waits = 0;
    presetn = 1;
    @(posedge pclk); #1;
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      mx(0, 1, 8'h61, 32'h6161_6161, 0);
      mx(1, 1, 8'h62, 32'h6262_6262, 0);
    join
    mx(1, 0, 8'h61, 32'h6161_6161, 0);

`ifdef APB_ARB_TIMEOUT_EN
    // watchdog: slave never answers
    slv_hang = 1;
    e.wr = 1; e.a = 8'h70; e.d = 32'h7070_7070; e.err = 1;
    q0.push_back(e);
    m0_psel = 1; m0_pwrite = 1; m0_paddr = 8'h70; m0_pwdata = 32'h7070_7070;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      if (s_psel && s_penable) acc++;
      if (m0_pready) break;
    end
    chk("to_access_cycles", acc, 16);
    chk("to_pslverr", 32'(m0_pslverr), 1);
    @(posedge pclk); #1 m0_psel = 0; m0_penable = 0;
    @(negedge pclk);
    chk("to_psel_drop", 32'(s_psel), 0);
    chk("to_pslverr_clear", 32'(m0_pslverr), 0);
    slv_hang = 0;
    mx(0, 0, 8'h61, 32'h6161_6161, 0);
`endif

    repeat (2) @(posedge pclk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("gq_empty", gq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
